// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the MIPS pipeline registers and the hazard controller.
// master = datapath side, slave = controller side.
interface pipe_hazard_ctrl_if #(
    parameter int RBITS   = 5,
    parameter int CNTBITS = 32
);
    logic [RBITS-1:0]   i_id_rs, i_id_rt;
    logic               i_id_use_rs, i_id_use_rt;
    logic               i_id_flush_req, i_id_halt;
    logic [RBITS-1:0]   i_ex_rd;
    logic               i_ex_regwrite, i_ex_memread;
    logic [RBITS-1:0]   i_mem_rd;
    logic               i_mem_regwrite, i_mem_access;
    logic [RBITS-1:0]   i_wb_rd;
    logic               i_wb_regwrite;
    logic               i_dbg_mode, i_dbg_step;
    logic [1:0]         o_fwd_a, o_fwd_b;
    logic               o_write_pc, o_ifid_write, o_ifid_flush;
    logic               o_idex_bubble, o_freeze, o_halted;
    logic [CNTBITS-1:0] o_cycle_cnt, o_stall_cnt;

    modport master (
        output i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_flush_req, i_id_halt,
               i_ex_rd, i_ex_regwrite, i_ex_memread, i_mem_rd, i_mem_regwrite,
               i_mem_access, i_wb_rd, i_wb_regwrite, i_dbg_mode, i_dbg_step,
        input  o_fwd_a, o_fwd_b, o_write_pc, o_ifid_write, o_ifid_flush,
               o_idex_bubble, o_freeze, o_halted, o_cycle_cnt, o_stall_cnt
    );

    modport slave (
        input  i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_flush_req, i_id_halt,
               i_ex_rd, i_ex_regwrite, i_ex_memread, i_mem_rd, i_mem_regwrite,
               i_mem_access, i_wb_rd, i_wb_regwrite, i_dbg_mode, i_dbg_step,
        output o_fwd_a, o_fwd_b, o_write_pc, o_ifid_write, o_ifid_flush,
               o_idex_bubble, o_freeze, o_halted, o_cycle_cnt, o_stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard / pipeline-control unit for the 5-stage MIPS datapath:
// forwarding selects, load-use stall, branch flush, data-memory wait,
// HALT drain, debug single-step and performance counters.
module pipe_hazard_ctrl #(
    parameter int RBITS   = 5,
    parameter int MEM_LAT = 0,
    parameter int CNTBITS = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [2:0] {RUN, MEMWAIT, DRAIN, HALTED, STEPHOLD} state_t;

    localparam logic [3:0] LAT      = 4'(MEM_LAT);
    localparam bit         HAS_WAIT = (MEM_LAT > 0);

    state_t             state_q, ret_q;
    logic [1:0]         drain_q;
    logic [3:0]         wait_q;
    logic               done_q;       // access in MEM has finished its wait
    logic               step_q;       // previous i_dbg_step level
    logic [CNTBITS-1:0] cyc_q, cyc_d, stall_q, stall_d;

    logic ex_ok, mem_ok, wb_ok, load_use, frozen, mem_trig, step_rise;
    logic wpc, ifw, ifl, bub, frz;

    // First match in EX, MEM, WB order wins; 00 selects the register bank.
    function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m, input logic wb_m);
        if (ex_m)       return 2'b01;
        else if (mem_m) return 2'b10;
        else if (wb_m)  return 2'b11;
        else            return 2'b00;
    endfunction

    assign ex_ok  = bus.i_ex_regwrite  && (bus.i_ex_rd  != '0);
    assign mem_ok = bus.i_mem_regwrite && (bus.i_mem_rd != '0);
    assign wb_ok  = bus.i_wb_regwrite  && (bus.i_wb_rd  != '0);

    assign load_use = bus.i_ex_memread && (bus.i_ex_rd != '0) &&
                      ((bus.i_id_use_rs && bus.i_ex_rd == bus.i_id_rs) ||
                       (bus.i_id_use_rt && bus.i_ex_rd == bus.i_id_rt));

    assign frozen    = (state_q == MEMWAIT) || (state_q == HALTED) || (state_q == STEPHOLD);
    // The access re-presented right after a wait is the completing one, not a new request.
    assign mem_trig  = bus.i_mem_access && HAS_WAIT && !done_q;
    assign step_rise = bus.i_dbg_step && !step_q;

    // Pipeline register controls, priority freeze > drain > load_use > flush.
    always_comb begin
        wpc = 1'b0;
        ifw = 1'b0;
        ifl = 1'b0;
        bub = 1'b0;
        frz = 1'b0;
        if (!i_rst || frozen) begin
            frz = 1'b1;
        end else if (state_q == DRAIN) begin
            bub = 1'b1;
        end else if (load_use) begin
            bub = 1'b1;
        end else if (bus.i_id_flush_req) begin
            ifl = 1'b1;
            wpc = 1'b1;
        end else begin
            wpc = 1'b1;
            ifw = 1'b1;
        end
    end

    assign bus.o_write_pc    = wpc;
    assign bus.o_ifid_write  = ifw;
    assign bus.o_ifid_flush  = ifl;
    assign bus.o_idex_bubble = bub;
    assign bus.o_freeze      = frz;
    assign bus.o_halted      = (state_q == HALTED);
    assign bus.o_fwd_a = i_rst ? fwd_sel(ex_ok  && bus.i_ex_rd  == bus.i_id_rs,
                                         mem_ok && bus.i_mem_rd == bus.i_id_rs,
                                         wb_ok  && bus.i_wb_rd  == bus.i_id_rs) : 2'b00;
    assign bus.o_fwd_b = i_rst ? fwd_sel(ex_ok  && bus.i_ex_rd  == bus.i_id_rt,
                                         mem_ok && bus.i_mem_rd == bus.i_id_rt,
                                         wb_ok  && bus.i_wb_rd  == bus.i_id_rt) : 2'b00;
    assign bus.o_cycle_cnt   = cyc_q;
    assign bus.o_stall_cnt   = stall_q;

    // Saturating performance counters, advancing cycles only.
    always_comb begin
        cyc_d   = cyc_q;
        stall_d = stall_q;
        if (!frozen) begin
            if (~&cyc_q)                cyc_d   = cyc_q + 1'b1;
            if (load_use && ~&stall_q)  stall_d = stall_q + 1'b1;
        end
    end

    // Control FSM; a wait taken during DRAIN returns to DRAIN (or HALTED on the last step).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            drain_q <= 2'd0;
            wait_q  <= 4'd0;
            done_q  <= 1'b0;
            step_q  <= 1'b0;
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            step_q  <= bus.i_dbg_step;
            cyc_q   <= cyc_d;
            stall_q <= stall_d;
            case (state_q)
                RUN: begin
                    done_q <= 1'b0;
                    if (mem_trig) begin
                        state_q <= MEMWAIT;
                        wait_q  <= LAT;
                        ret_q   <= RUN;
                    end else if (bus.i_id_halt && !load_use) begin
                        state_q <= DRAIN;
                        drain_q <= 2'd3;
                    end else if (bus.i_dbg_mode) begin
                        state_q <= STEPHOLD;
                    end
                end
                MEMWAIT: begin
                    if (wait_q <= 4'd1) begin
                        state_q <= ret_q;
                        done_q  <= 1'b1;
                    end else begin
                        wait_q  <= wait_q - 4'd1;
                    end
                end
                DRAIN: begin
                    done_q  <= 1'b0;
                    drain_q <= drain_q - 2'd1;
                    if (mem_trig) begin
                        state_q <= MEMWAIT;
                        wait_q  <= LAT;
                        ret_q   <= (drain_q == 2'd1) ? HALTED : DRAIN;
                    end else if (drain_q == 2'd1) begin
                        state_q <= HALTED;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                STEPHOLD: begin
                    if (!bus.i_dbg_mode || step_rise) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// expectations from an abstract cycle model, checked by a separate monitor.
module tb_pipe_hazard_ctrl;
    localparam int RBITS   = 5;
    localparam int MEM_LAT = 3;
    localparam int CNTBITS = 8;
    localparam int CMAX    = (1 << CNTBITS) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RBITS(RBITS), .CNTBITS(CNTBITS)) bus();
    pipe_hazard_ctrl #(.RBITS(RBITS), .MEM_LAT(MEM_LAT), .CNTBITS(CNTBITS)) dut (
        .i_clk(clk), .i_rst(rst_n), .bus(bus)
    );

    typedef struct {
        bit rst; int rs; int rt; bit use_rs; bit use_rt; bit flush; bit halt;
        int ex_rd; bit ex_rw; bit ex_mr; int mem_rd; bit mem_rw; bit mem_acc;
        int wb_rd; bit wb_rw; bit dbg_mode; bit dbg_step;
    } in_t;
    typedef struct {
        int fa; int fb; bit wpc; bit ifw; bit ifl; bit bub; bit frz; bit hlt; int cyc; int stl;
    } exp_t;

    exp_t sbq[$];
    int   npass = 0;
    int   ntot  = 0;

    // Abstract model: remaining wait cycles, remaining drain steps, flags.
    int m_wait, m_drain, m_cyc, m_stl;
    bit m_halted, m_hold, m_done, m_pend_halt, m_prev_step;

    function automatic int fwd(in_t s, int src);
        if (s.ex_rw  && s.ex_rd  != 0 && s.ex_rd  == src) return 1;
        if (s.mem_rw && s.mem_rd != 0 && s.mem_rd == src) return 2;
        if (s.wb_rw  && s.wb_rd  != 0 && s.wb_rd  == src) return 3;
        return 0;
    endfunction

    function automatic bit lu(in_t s);
        return s.ex_mr && s.ex_rd != 0 &&
               ((s.use_rs && s.ex_rd == s.rs) || (s.use_rt && s.ex_rd == s.rt));
    endfunction

    function automatic bit frozen();
        return (m_wait > 0) || m_halted || m_hold;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_drain = 0; m_cyc = 0; m_stl = 0;
        m_halted = 0; m_hold = 0; m_done = 0; m_pend_halt = 0; m_prev_step = 0;
    endtask

    function automatic exp_t expect_of(in_t s);
        exp_t e;
        e = '{default: 0};
        if (!s.rst) begin
            e.frz = 1;
            return e;
        end
        e.fa = fwd(s, s.rs);
        e.fb = fwd(s, s.rt);
        e.hlt = m_halted;
        e.cyc = m_cyc;
        e.stl = m_stl;
        if (frozen())            e.frz = 1;
        else if (m_drain > 0)    e.bub = 1;
        else if (lu(s))          e.bub = 1;
        else if (s.flush) begin  e.ifl = 1; e.wpc = 1; end
        else begin               e.wpc = 1; e.ifw = 1; end
        return e;
    endfunction

    task automatic model_edge(in_t s);
        bit fz, l, trig;
        fz   = frozen();
        l    = lu(s);
        trig = s.mem_acc && (MEM_LAT > 0) && !m_done;
        if (!fz) begin
            if (m_cyc < CMAX) m_cyc++;
            if (l && m_stl < CMAX) m_stl++;
        end
        if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                if (m_pend_halt) begin m_halted = 1; m_pend_halt = 0; end
                else m_done = 1;
            end
        end else if (m_halted) begin
            m_halted = 1;
        end else if (m_hold) begin
            if (!s.dbg_mode || (s.dbg_step && !m_prev_step)) m_hold = 0;
        end else if (m_drain > 0) begin
            m_done = 0;
            m_drain--;
            if (trig) begin
                m_wait = MEM_LAT;
                m_pend_halt = (m_drain == 0);
            end else if (m_drain == 0) m_halted = 1;
        end else begin
            m_done = 0;
            if (trig)                   m_wait = MEM_LAT;
            else if (s.halt && !l)      m_drain = 3;
            else if (s.dbg_mode)        m_hold = 1;
        end
        m_prev_step = s.dbg_step;
    endtask

    task automatic drive(in_t s);
        rst_n                = s.rst;
        bus.i_id_rs          = RBITS'(s.rs);
        bus.i_id_rt          = RBITS'(s.rt);
        bus.i_id_use_rs      = s.use_rs;
        bus.i_id_use_rt      = s.use_rt;
        bus.i_id_flush_req   = s.flush;
        bus.i_id_halt        = s.halt;
        bus.i_ex_rd          = RBITS'(s.ex_rd);
        bus.i_ex_regwrite    = s.ex_rw;
        bus.i_ex_memread     = s.ex_mr;
        bus.i_mem_rd         = RBITS'(s.mem_rd);
        bus.i_mem_regwrite   = s.mem_rw;
        bus.i_mem_access     = s.mem_acc;
        bus.i_wb_rd          = RBITS'(s.wb_rd);
        bus.i_wb_regwrite    = s.wb_rw;
        bus.i_dbg_mode       = s.dbg_mode;
        bus.i_dbg_step       = s.dbg_step;
    endtask

    in_t s, prev, base;

    // One clock: advance the model across the edge, then apply the next inputs.
    task automatic step(in_t ns);
        @(posedge clk);
        if (prev.rst) model_edge(prev);
        #1;
        drive(ns);
        if (!ns.rst) model_reset();
        sbq.push_back(expect_of(ns));
        prev = ns;
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act !== exp)
            $display("FAIL %s t=%0t actual=%0d required=%0d", n, $time, act, exp);
        else
            npass++;
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("fwd_a",       bus.o_fwd_a,       e.fa);
                chk("fwd_b",       bus.o_fwd_b,       e.fb);
                chk("write_pc",    bus.o_write_pc,    e.wpc);
                chk("ifid_write",  bus.o_ifid_write,  e.ifw);
                chk("ifid_flush",  bus.o_ifid_flush,  e.ifl);
                chk("idex_bubble", bus.o_idex_bubble, e.bub);
                chk("freeze",      bus.o_freeze,      e.frz);
                chk("halted",      bus.o_halted,      e.hlt);
                chk("cycle_cnt",   bus.o_cycle_cnt,   e.cyc);
                chk("stall_cnt",   bus.o_stall_cnt,   e.stl);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic randomize_in(inout in_t r, input bit allow_ctl);
        r.rs = $urandom_range(0, 3);     r.rt = $urandom_range(0, 3);
        r.use_rs = $urandom_range(0, 1); r.use_rt = $urandom_range(0, 1);
        r.flush = ($urandom_range(0, 3) == 0);
        r.ex_rd = $urandom_range(0, 3);  r.ex_rw = $urandom_range(0, 1);
        r.ex_mr = $urandom_range(0, 1);
        r.mem_rd = $urandom_range(0, 3); r.mem_rw = $urandom_range(0, 1);
        r.mem_acc = ($urandom_range(0, 5) == 0) || (prev.mem_acc && $urandom_range(0, 1) == 0);
        r.wb_rd = $urandom_range(0, 3);  r.wb_rw = $urandom_range(0, 1);
        r.halt = 0;
        r.rst = 1;
        if (allow_ctl) begin
            r.halt = ($urandom_range(0, 99) == 0);
            r.dbg_mode = prev.dbg_mode ^ ($urandom_range(0, 39) == 0);
            r.dbg_step = ($urandom_range(0, 3) == 0) ? !prev.dbg_step : prev.dbg_step;
            r.rst = !(($urandom_range(0, 399) == 0) ||
                      (m_halted && $urandom_range(0, 15) == 0) ||
                      (!prev.rst && $urandom_range(0, 1) == 0));
        end
    endtask

    initial begin
        base = '{default: 0};
        base.rst = 1;
        s = base;
        s.rst = 0;
        prev = s;
        model_reset();
        repeat (2) step(s);
        s = base; step(s);

        // forwarding: EX wins over MEM, rd=0 never forwarded, WB on rt
        s.ex_rw = 1; s.ex_rd = 5; s.mem_rw = 1; s.mem_rd = 5; s.rs = 5; s.use_rs = 1; step(s);
        s.ex_rd = 0; s.mem_rd = 0; s.rs = 0; step(s);
        s.wb_rw = 1; s.wb_rd = 7; s.rt = 7; step(s);
        s.mem_rd = 7; step(s);

        // load-use with a simultaneous flush, then a plain flush
        s = base; s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 3; s.rt = 3; s.use_rt = 1; s.flush = 1; step(s);
        s = base; s.flush = 1; step(s);
        s = base; step(s);

        // memory wait: access held through its completion, then a single pulse
        s.mem_acc = 1; repeat (5) step(s);
        s = base; step(s);
        s.mem_acc = 1; step(s);
        s = base; repeat (5) step(s);

        // single-step: step level held high gives one advancing cycle
        s.dbg_mode = 1; repeat (3) step(s);
        s.dbg_step = 1; repeat (5) step(s);
        s.dbg_step = 0; repeat (2) step(s);
        s.dbg_step = 1; repeat (2) step(s);
        s.dbg_mode = 0; repeat (3) step(s);

        // reset in MEMWAIT with two cycles left
        s = base; s.mem_acc = 1; step(s); step(s);
        s = base; s.rst = 0; step(s);
        s = base; repeat (3) step(s);

        // HALT drain, stays halted until reset
        s.halt = 1; step(s);
        s = base; repeat (8) step(s);
        s.rst = 0; step(s);
        s = base; step(s);

        // HALT with memory waits inside the drain, including the last step
        s.halt = 1; step(s);
        s = base; s.mem_acc = 1; repeat (2) step(s);
        s = base; step(s);
        s.mem_acc = 1; repeat (6) step(s);
        s = base; s.rst = 0; step(s);
        s = base; step(s);

        // HALT blocked by load-use
        s.halt = 1; s.ex_mr = 1; s.ex_rd = 2; s.rs = 2; s.use_rs = 1; step(s);
        s = base; repeat (2) step(s);

        // long free run to saturate the cycle counter
        s = base; s.rst = 0; step(s);
        s = base;
        for (int i = 0; i < 320; i++) begin
            randomize_in(s, 1'b0);
            step(s);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            randomize_in(s, 1'b1);
            step(s);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
